// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets, STATUS layout, serializer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a. The PARITY state exists only when UART_TX_PARITY_EN is defined.
package mmio_uart_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [31:0] DATA_OFF   = 32'd0;
  localparam logic [31:0] STATUS_OFF = 32'd4;

  // STATUS register bit positions
  localparam int ST_BUSY_BIT = 0;
  localparam int ST_FULL_BIT = 1;
  localparam int ST_CNT_LSB  = 2;
  localparam int ST_CNT_MSB  = 4;
  localparam int ST_OVF_BIT  = 5;

  // Serializer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } tx_state_e;

`ifdef UART_TX_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART serializer.
// Latency: a pushed byte is visible on dout/empty the cycle after the push edge.
// Backpressure: a push while full is ignored unless a pop happens on the same edge.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  // A pop on the same edge frees a slot, so a push into a full FIFO is still taken then
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state for storage, pointers (wrap naturally at power-of-two depth) and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: DATA register pushes bytes into a FIFO, STATUS reports busy/full/count/ovf.
// Latency: rdata one cycle after addr; a byte pushed into an idle block starts its START bit one edge later.
// Backpressure: pushes into a full FIFO are dropped and latch sticky ovf. Optional parity via UART_TX_PARITY_EN.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        tx,
  output logic        irq
);

  localparam int          CW          = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] DATA_ADDR   = BASE_ADDR + DATA_OFF;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + STATUS_OFF;
  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

  // Address decode is purely combinational and ignores reset
  logic hit_data, hit_status, wr_data, wr_status;
  assign hit_data   = (addr == DATA_ADDR);
  assign hit_status = (addr == STATUS_ADDR);
  assign hit        = hit_data | hit_status;
  assign wr_data    = we && hit_data;
  assign wr_status  = we && hit_status;

  // FIFO
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [4:0]    cnt_ext;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .pop   (fifo_pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cnt_ext = 5'(fifo_count);

  // Serializer and register state
  tx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic        ovf_q, ovf_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] status_word;
  logic        busy;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign busy  = (state_q != ST_IDLE);
  assign irq   = fifo_empty && !busy;
  assign rdata = rdata_q;

  logic unused_bits;
  assign unused_bits = ^{wdata[31:8], cnt_ext[4:3]};

  // STATUS composition, sticky overflow flag and registered read data
  always_comb begin
    status_word                          = '0;
    status_word[ST_BUSY_BIT]             = busy;
    status_word[ST_FULL_BIT]             = fifo_full;
    status_word[ST_CNT_MSB:ST_CNT_LSB]   = cnt_ext[2:0];
    status_word[ST_OVF_BIT]              = ovf_q;

    ovf_d = ovf_q;
    if (wr_data && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
    if (wr_status && wdata[ST_OVF_BIT]) begin
      ovf_d = 1'b0;
    end

    rdata_d = hit_status ? status_word : 32'd0;
  end

  // Serializer next-state, FIFO pop and tx line; baud counter reloads on every bit boundary
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    fifo_pop   = 1'b0;
    tx         = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d    = ST_START;
          fifo_pop   = 1'b1;
          shift_d    = fifo_dout;
          bit_cnt_d  = 3'd0;
          baud_cnt_d = BAUD_RELOAD;
`ifdef UART_TX_PARITY_EN
          parity_d   = even_parity(fifo_dout);
`endif
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (baud_cnt_q == 16'd0) begin
          state_d    = ST_DATA;
          bit_cnt_d  = 3'd0;
          baud_cnt_d = BAUD_RELOAD;
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        tx = shift_q[0];
        if (baud_cnt_q == 16'd0) begin
          baud_cnt_d = BAUD_RELOAD;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
            bit_cnt_d = 3'd0;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx = parity_q;
        if (baud_cnt_q == 16'd0) begin
          state_d    = ST_STOP;
          baud_cnt_d = BAUD_RELOAD;
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
`endif
      ST_STOP: begin
        tx = 1'b1;
        if (baud_cnt_q == 16'd0) begin
          if (!fifo_empty) begin
            // Back-to-back frame: no idle bit between STOP and the next START
            state_d    = ST_START;
            fifo_pop   = 1'b1;
            shift_d    = fifo_dout;
            bit_cnt_d  = 3'd0;
            baud_cnt_d = BAUD_RELOAD;
`ifdef UART_TX_PARITY_EN
            parity_d   = even_parity(fifo_dout);
`endif
          end else begin
            state_d    = ST_IDLE;
            baud_cnt_d = 16'd0;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        baud_cnt_d = 16'd0;
        bit_cnt_d  = 3'd0;
      end
    endcase
  end

  // State registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      baud_cnt_q <= 16'd0;
      ovf_q      <= 1'b0;
      rdata_q    <= 32'd0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      ovf_q      <= ovf_d;
      rdata_q    <= rdata_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Backpressure: exercises FIFO fill, dropped push with ovf, and back-to-back frames.
module tb_mmio_uart_tx;

  localparam int          CPB    = 4;
  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam logic [31:0] STATUS = 32'h0000_0104;
`ifdef UART_TX_PARITY_EN
  localparam int          NSLOTS = 11;
  localparam bit          PAR    = 1'b1;
`else
  localparam int          NSLOTS = 10;
  localparam bit          PAR    = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        hit;
  logic        tx;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .rdata (rdata),
    .hit   (hit),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    addr  = BASE;
    wdata = {24'h0, b};
    we    = 1'b1;
    tick();
    we    = 1'b0;
    addr  = 32'h0;
  endtask

  // Sample tx once per cycle across a whole frame, starting at the first START cycle
  task automatic check_frame(input logic [7:0] b);
    int   slot;
    logic exp;
    for (int i = 0; i < NSLOTS * CPB; i++) begin
      slot = i / CPB;
      if (slot == 0)                  exp = 1'b0;
      else if (slot <= 8)             exp = b[slot-1];
      else if (PAR && slot == 9)      exp = ^b;
      else                            exp = 1'b1;
      check($sformatf("tx_%h[%0d]", b, i), {31'b0, tx}, {31'b0, exp});
      if (i == 0 || i == NSLOTS * CPB - 1)
        check($sformatf("irq_busy_%h[%0d]", b, i), {31'b0, irq}, 32'd0);
      tick();
    end
  endtask

  initial begin
    int budget;
    reset = 1'b0;
    addr  = STATUS;
    wdata = 32'h0;
    we    = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_tx",    {31'b0, tx},  32'd1);
    check("rst_irq",   {31'b0, irq}, 32'd1);
    check("rst_rdata", rdata,        32'd0);
    addr = BASE;
    #1;
    check("rst_hit", {31'b0, hit}, 32'd1);
    reset = 1'b1;
    addr  = STATUS;
    tick();
    check("idle_status", rdata, 32'd0);

    // Single 8'hA5 frame, exactly 40 cycles, then idle
    push(8'hA5);
    tick();
    check_frame(8'hA5);
    check("a5_irq_after", {31'b0, irq}, 32'd1);
    check("a5_tx_after",  {31'b0, tx},  32'd1);
    addr = STATUS;
    tick();
    check("a5_status_idle", rdata, 32'd0);

    // Five back-to-back pushes: first popped, four fill the FIFO
    for (int k = 0; k < 5; k++) begin
      addr  = BASE;
      wdata = 32'h11 + k;
      we    = 1'b1;
      tick();
    end
    we   = 1'b0;
    addr = STATUS;
    tick();
    check("fill_status", rdata, 32'h13);
    // Sixth push is dropped and sets ovf
    push(8'h16);
    addr = STATUS;
    tick();
    check("ovf_status", rdata, 32'h33);
    // Clear ovf through STATUS
    addr  = STATUS;
    wdata = 32'h20;
    we    = 1'b1;
    tick();
    we    = 1'b0;
    tick();
    check("ovf_clr_status", rdata, 32'h13);

    // Reset at frame cycle 10 aborts frame and flushes queue
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_tx",    {31'b0, tx},  32'd1);
    check("midrst_irq",   {31'b0, irq}, 32'd1);
    check("midrst_rdata", rdata,        32'd0);
    addr = STATUS;
    tick();
    check("midrst_status", rdata, 32'd0);

    // Two queued bytes: frames abut with no idle cycles
    push(8'h3C);
    push(8'hC3);
    check_frame(8'h3C);
    check_frame(8'hC3);
    check("b2b_irq_after", {31'b0, irq}, 32'd1);
    check("b2b_tx_after",  {31'b0, tx},  32'd1);

    // STATUS with three queued while busy, then out-of-range and DATA reads
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    addr = STATUS;
    tick();
    check("q3_status", rdata, 32'h0000_000D);
    addr = BASE + 32'd8;
    #1;
    check("miss_hit", {31'b0, hit}, 32'd0);
    tick();
    check("miss_rdata", rdata, 32'd0);
    addr = BASE;
    tick();
    check("data_hit",   {31'b0, hit}, 32'd1);
    check("data_rdata", rdata,        32'd0);
    addr = 32'h0;
    budget = 0;
    while (irq !== 1'b1 && budget < 1000) begin
      tick();
      budget++;
    end
    check("drain_irq", {31'b0, irq}, 32'd1);
    check("drain_tx",  {31'b0, tx},  32'd1);

`ifdef UART_TX_PARITY_EN
    // 8'h07 has odd weight: parity bit 1, frame 11 bit times
    push(8'h07);
    tick();
    check_frame(8'h07);
    check("par_irq_after", {31'b0, irq}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
